// File: rtl/tdm_noc_lut_conf_master.sv
// Slot-table configuration initiator: turns write / clear-port / clear-all
// commands into one-cycle lut_conf_* strobes broadcast to a router's slot
// tables. Malformed commands are dropped and flagged with an err pulse.
module tdm_noc_lut_conf_master #(
  parameter int PORTS    = 5,
  parameter int LUT_SIZE = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [$clog2(PORTS)-1:0]     cmd_sel,
  input  logic [$clog2(LUT_SIZE)-1:0]  cmd_slot,
  input  logic [$clog2(PORTS+1)-1:0]   cmd_data,
  output logic                         lut_conf_valid,
  output logic [$clog2(PORTS)-1:0]     lut_conf_sel,
  output logic [$clog2(LUT_SIZE)-1:0]  lut_conf_slot,
  output logic [$clog2(PORTS+1)-1:0]   lut_conf_data,
  output logic                         done,
  output logic                         err
);
  localparam int SW = $clog2(PORTS);
  localparam int LW = $clog2(LUT_SIZE);
  localparam int DW = $clog2(PORTS+1);

  localparam logic [LW-1:0] SLOT_LAST = LW'(LUT_SIZE-1);
  localparam logic [LW-1:0] SLOT_PEN  = LW'(LUT_SIZE-2);
  localparam logic [SW-1:0] SEL_LAST  = SW'(PORTS-1);
  localparam logic [DW-1:0] IDLE_DATA = '1;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_CLRP  = 2'b01;
  localparam logic [1:0] OP_CLRA  = 2'b10;

  // Reject unsupported geometry at elaboration time.
  generate
    if (LUT_SIZE < 2 || (LUT_SIZE & (LUT_SIZE-1)) != 0) begin : g_bad_lut
      $error("LUT_SIZE must be a power of two >= 2");
    end
    if (PORTS < 2) begin : g_bad_ports
      $error("PORTS must be >= 2");
    end
  endgenerate

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state_q, state_d;
  logic            all_q, all_d;       // current clear walks every port
  logic            valid_d, done_d, err_d;
  logic [SW-1:0]   sel_d;
  logic [LW-1:0]   slot_d;
  logic [DW-1:0]   data_d;
  logic            sel_ok, data_ok;

  assign cmd_ready = (state_q == IDLE);
  assign sel_ok    = int'(cmd_sel) < PORTS;
  assign data_ok   = (int'(cmd_data) < PORTS) || (cmd_data == IDLE_DATA);

  // State register; reset abandons any clear in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      all_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      all_q   <= all_d;
    end
  end

  // Next state and next strobe. The output registers double as the clear
  // walk counters: sel/slot of the current strobe drive the next one.
  always_comb begin
    state_d = state_q;
    all_d   = all_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    sel_d   = lut_conf_sel;
    slot_d  = lut_conf_slot;
    data_d  = lut_conf_data;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_WRITE: begin
              if (sel_ok && data_ok) begin
                valid_d = 1'b1;
                sel_d   = cmd_sel;
                slot_d  = cmd_slot;
                data_d  = cmd_data;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_CLRP: begin
              if (sel_ok) begin
                valid_d = 1'b1;
                sel_d   = cmd_sel;
                slot_d  = '0;
                data_d  = IDLE_DATA;
                all_d   = 1'b0;
                state_d = CLEAR;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_CLRA: begin
              valid_d = 1'b1;
              sel_d   = '0;
              slot_d  = '0;
              data_d  = IDLE_DATA;
              all_d   = 1'b1;
              state_d = CLEAR;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      CLEAR: begin
        valid_d = 1'b1;
        data_d  = IDLE_DATA;
        if (lut_conf_slot == SLOT_LAST) begin
          // only reachable in clear-all; port walk never passes SEL_LAST
          slot_d = '0;
          sel_d  = lut_conf_sel + SW'(1);
        end else begin
          slot_d = lut_conf_slot + LW'(1);
        end
        // Leave CLEAR together with the final strobe so a new command can
        // be accepted in the same cycle that strobe is visible.
        if (lut_conf_slot == SLOT_PEN && (!all_q || lut_conf_sel == SEL_LAST)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered strobe outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lut_conf_valid <= 1'b0;
      lut_conf_sel   <= '0;
      lut_conf_slot  <= '0;
      lut_conf_data  <= '0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      lut_conf_valid <= valid_d;
      lut_conf_sel   <= sel_d;
      lut_conf_slot  <= slot_d;
      lut_conf_data  <= data_d;
      done           <= done_d;
      err            <= err_d;
    end
  end
endmodule

// File: tb/tb_tdm_noc_lut_conf_master.sv
// Randomised bench for tdm_noc_lut_conf_master against a queue-based model:
// every accepted command expands into the list of per-cycle outputs it owes.
module tb_tdm_noc_lut_conf_master;
  localparam int PORTS    = 5;
  localparam int LUT_SIZE = 16;
  localparam int SW = $clog2(PORTS);
  localparam int LW = $clog2(LUT_SIZE);
  localparam int DW = $clog2(PORTS+1);
  localparam int ONES = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [SW-1:0] cmd_sel = '0;
  logic [LW-1:0] cmd_slot = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          lut_conf_valid;
  logic [SW-1:0] lut_conf_sel;
  logic [LW-1:0] lut_conf_slot;
  logic [DW-1:0] lut_conf_data;
  logic          done;
  logic          err;

  tdm_noc_lut_conf_master #(.PORTS(PORTS), .LUT_SIZE(LUT_SIZE)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_sel(cmd_sel), .cmd_slot(cmd_slot), .cmd_data(cmd_data),
    .lut_conf_valid(lut_conf_valid), .lut_conf_sel(lut_conf_sel),
    .lut_conf_slot(lut_conf_slot), .lut_conf_data(lut_conf_data),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int sel;
    int slot;
    int data;
    bit done;
    bit err;
  } ent_t;

  ent_t pend[$];
  bit   m_ready;
  int   last_sel, last_slot, last_data;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t mk(input bit v, input int sel, input int slot,
                              input int data, input bit dn, input bit er);
    ent_t e;
    e.v = v; e.sel = sel; e.slot = slot; e.data = data; e.done = dn; e.err = er;
    return e;
  endfunction

  // Expand an accepted command into the outputs it produces, cycle by cycle.
  task automatic model_accept(input int op, input int sel, input int slot, input int data);
    case (op)
      0: if (sel < PORTS && (data < PORTS || data == ONES))
           pend.push_back(mk(1, sel, slot, data, 0, 0));
         else
           pend.push_back(mk(0, 0, 0, 0, 0, 1));
      1: if (sel < PORTS)
           for (int s = 0; s < LUT_SIZE; s++)
             pend.push_back(mk(1, sel, s, ONES, s == LUT_SIZE-1, 0));
         else
           pend.push_back(mk(0, 0, 0, 0, 0, 1));
      2: for (int p = 0; p < PORTS; p++)
           for (int s = 0; s < LUT_SIZE; s++)
             pend.push_back(mk(1, p, s, ONES, (p == PORTS-1) && (s == LUT_SIZE-1), 0));
      default: pend.push_back(mk(0, 0, 0, 0, 0, 1));
    endcase
  endtask

  task automatic check_cycle();
    ent_t e;
    if (pend.size() > 0) e = pend.pop_front();
    else e = mk(0, 0, 0, 0, 0, 0);
    if (e.v) begin
      last_sel = e.sel; last_slot = e.slot; last_data = e.data;
    end
    m_ready = (pend.size() == 0);
    chk("valid", int'(lut_conf_valid), int'(e.v));
    chk("sel",   int'(lut_conf_sel),   last_sel);
    chk("slot",  int'(lut_conf_slot),  last_slot);
    chk("data",  int'(lut_conf_data),  last_data);
    chk("done",  int'(done),           int'(e.done));
    chk("err",   int'(err),            int'(e.err));
    chk("ready", int'(cmd_ready),      int'(m_ready));
  endtask

  // One clock: offer inputs, let the edge happen, check 1 time unit after.
  task automatic step(input bit v, input int op, input int sel, input int slot, input int data);
    cmd_valid = v;
    cmd_op    = 2'(op);
    cmd_sel   = SW'(sel);
    cmd_slot  = LW'(slot);
    cmd_data  = DW'(data);
    if (v && m_ready) model_accept(op, sel, slot, data);
    @(posedge clk);
    #1;
    check_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic garbage(input int n);
    for (int i = 0; i < n; i++)
      step(1, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 7));
  endtask

  task automatic reset_model();
    pend.delete();
    m_ready = 1;
    last_sel = 0; last_slot = 0; last_data = 0;
  endtask

  initial begin
    reset_model();
    #1;
    chk("rst_valid", int'(lut_conf_valid), 0);
    chk("rst_done",  int'(done), 0);
    chk("rst_err",   int'(err), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_sel",   int'(lut_conf_sel), 0);
    chk("rst_slot",  int'(lut_conf_slot), 0);
    chk("rst_data",  int'(lut_conf_data), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // single write
    step(1, 0, 2, 7, 3);
    idle(2);
    // back-to-back writes
    for (int i = 0; i < 4; i++) step(1, 0, 1, i, 4);
    idle(2);
    // clear port 4; busy-time commands must be ignored; write right at done
    step(1, 1, 4, 0, 0);
    garbage(15);
    step(1, 0, 3, 9, 2);
    idle(2);
    // clear all
    step(1, 2, 0, 0, 0);
    garbage(79);
    idle(2);
    // malformed commands
    step(1, 0, 5, 0, 1);
    step(1, 0, 1, 0, 5);
    step(1, 3, 0, 0, 0);
    step(1, 1, 6, 0, 0);
    idle(2);
    // reset in the middle of a port clear, at the fifth strobe
    step(1, 1, 1, 0, 0);
    idle(4);
    rst = 1'b1;
    #1;
    chk("midrst_valid", int'(lut_conf_valid), 0);
    chk("midrst_ready", int'(cmd_ready), 1);
    chk("midrst_done",  int'(done), 0);
    reset_model();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    step(1, 0, 2, 7, 3);
    idle(2);

    // randomised traffic
    for (int i = 0; i < 900; i++) begin
      int r, op, sel, data;
      r  = $urandom_range(0, 99);
      op = (r < 70) ? 0 : (r < 78) ? 1 : (r < 80) ? 2 : 3;
      sel  = ($urandom_range(0, 99) < 85) ? $urandom_range(0, PORTS-1) : $urandom_range(PORTS, 7);
      r    = $urandom_range(0, 99);
      data = (r < 80) ? $urandom_range(0, PORTS-1) : (r < 90) ? ONES : $urandom_range(PORTS, ONES-1);
      step($urandom_range(0, 99) < 80, op, sel, $urandom_range(0, LUT_SIZE-1), data);
    end
    idle(LUT_SIZE * PORTS + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tdm_noc_lut_conf_master.md
Name: tdm_noc_lut_conf_master

Overview:
- Initiator side of the slot-table configuration interface.
- Accepts configuration commands (single slot write, clear one port, clear all ports) from the control-network endpoint over a valid/ready handshake.
- Serialises them into one-cycle lut_conf_* write strobes broadcast to all per-output slot tables of one router.
- Rejects malformed commands with an error pulse, so slot tables never see an invalid write.

Parameters:
PORTS, 5, number of router ports; sets sel/data widths.
LUT_SIZE, 16, slots per table; power of two; elaboration fails otherwise.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at posedge
cmd_op  in  2  00 write slot, 01 clear port, 10 clear all, 11 reserved
cmd_sel  in  $clog2(PORTS)  target output port
cmd_slot  in  $clog2(LUT_SIZE)  target slot (write only)
cmd_data  in  $clog2(PORTS+1)  input select to store (write only)
lut_conf_valid  out  1  write strobe to slot tables
lut_conf_sel  out  $clog2(PORTS)  output port addressed
lut_conf_slot  out  $clog2(LUT_SIZE)  slot addressed
lut_conf_data  out  $clog2(PORTS+1)  value written; all-ones = idle slot
done  out  1  one-cycle pulse on last write of a clear op
err  out  1  one-cycle pulse for a rejected command

Behaviour:
- Reset (async assert, sync-safe release):
  - State IDLE.
  - cmd_ready=1.
  - lut_conf_valid, done, err = 0.
  - lut_conf_sel/slot/data = 0.
  - Counters = 0.
- All outputs are registered except cmd_ready, which is (state==IDLE).
- States: IDLE, CLEAR.
- Validity checks at acceptance:
  - cmd_sel < PORTS for ops 00/01.
  - cmd_data < PORTS or all-ones for op 00.
  - op 11 is always invalid.
  - Invalid command: accepted (ready stays 1); next cycle err=1, lut_conf_valid=0, state unchanged.
- Write slot (op 00, valid):
  - Next cycle lut_conf_valid=1 with sel/slot/data copies; latency 1.
  - Stays in IDLE, so back-to-back writes run at one per cycle.
- Clear port (op 01, valid):
  - Go to CLEAR, latch sel.
  - Emit LUT_SIZE consecutive strobes, slot 0..LUT_SIZE-1, data all-ones, starting the cycle after acceptance.
  - cmd_ready=0 during the first LUT_SIZE-1 strobe cycles.
  - In the cycle showing the last strobe: state is IDLE, cmd_ready=1, done=1.
  - A command accepted there produces output in the immediately following cycle, with no gap.
- Clear all (op 10): same as clear port, but iterates sel 0..PORTS-1 (outer) and slot 0..LUT_SIZE-1 (inner). PORTS*LUT_SIZE strobes; done on the last (sel=PORTS-1, slot=LUT_SIZE-1).
- Slot counter wraps LUT_SIZE-1 -> 0 and increments sel only in clear all. The sel counter never reaches PORTS.
- cmd_* inputs are ignored when cmd_ready=0.
- In cycles with no strobe, lut_conf_valid=0; sel/slot/data hold their last value.
- Reset mid-CLEAR: immediate return to IDLE with no further strobes. The partial clear is harmless because the slot tables reset to idle too.
- No readback. No check for conflicting schedules; that is software's job.

Test Plan (PORTS=5, LUT_SIZE=16):
1. Reset, then write op sel=2 slot=7 data=3 -> one cycle later a single strobe sel=2 slot=7 data=3; err=0, done=0, cmd_ready constantly 1.
2. Four writes on consecutive cycles (slots 0,1,2,3, data 4) -> four strobes on four consecutive cycles, in order, with no bubbles.
3. Clear port sel=4 -> 16 strobes sel=4 slot 0..15 data=7; cmd_ready low for 15 cycles; done coincides with slot=15; a write offered then appears on the next cycle.
4. Clear all -> 80 strobes, sel 0..4 × slot 0..15 data=7; done only on sel=4 slot=15; exactly one done pulse.
5. Invalid commands (write sel=5; write data=5; op=11; clear port sel=6) -> err pulse 1 cycle after each; zero strobes; state stays IDLE.
6. Assert rst at strobe 5 of clear port sel=1 -> lut_conf_valid=0 immediately; cmd_ready=1; no done; a new write after release behaves as in scenario 1.
